mem_pipe_param: RTL and testbench

- Parametrised successor to the single-port `mem` block.
- Single-port synchronous RAM with a valid/ready request handshake and per-byte write enables.
- Read latency is configurable; out-of-range addresses are detected and flagged.
- Sits behind the testbench interface as the DUT; the next generation of the memory model for the SV_TB memory environment.

---
 rtl/mem_pipe_param.sv | 194 +++++++++++++++++++
 tb/tb_mem_pipe_param.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_pipe_param.sv
// ---------------------------------------------------------------------------
// mem_pipe_param
// Single-port synchronous RAM with a valid/ready request handshake, per-byte
// write enables, a configurable read latency (RD_LAT = 1..4) and detection of
// out-of-range addresses.
//
// Ports
//   clk        rising-edge clock for all logic
//   rst        asynchronous, active-low reset
//   req_valid  request present
//   req_ready  block accepts a request this cycle (high only in RUN)
//   wr_rd      1 = write, 0 = read
//   addr       word address
//   wr_data    write data
//   wr_be      byte enables, bit i covers wr_data[8i+7:8i]
//   rd_valid   one-cycle pulse per read response
//   rd_data    read response data, held while rd_valid is low
//   rd_err     qualifies rd_valid: the read address was out of range
//   wr_err     one-cycle pulse: an accepted write was out of range, dropped
//
// Build option
//   MEM_CLEAR_EN  when defined, every reset is followed by a CLEAR phase that
//                 writes zero to all DEPTH words, one per cycle, before the
//                 block becomes ready. Undefined: contents survive reset.
// ---------------------------------------------------------------------------
module mem_pipe_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                wr_rd,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_err,
  output logic                wr_err
);

  localparam int unsigned BE_W = DATA_W / 8;

`ifdef MEM_CLEAR_EN
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1
  } state_e;
`endif

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic                          accept;
  logic                          in_range;
  logic                          wr_accept;
  logic                          rd_accept;
  logic [DATA_W-1:0]             rd_word;
  logic                          wr_err_q, wr_err_d;
  logic [RD_LAT-1:0]             pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0]             pipe_err_q, pipe_err_d;
  logic [RD_LAT-1:0][DATA_W-1:0] pipe_dat_q, pipe_dat_d;
  logic                          clr_we;
  logic [ADDR_W-1:0]             clr_addr;

  assign req_ready = (state_q == ST_RUN);
  assign accept    = req_valid && req_ready;
  assign in_range  = (32'(addr) < DEPTH);
  assign wr_accept = accept && wr_rd;
  assign rd_accept = accept && !wr_rd;
  // Out-of-range reads return zero rather than whatever the index aliases to.
  assign rd_word   = in_range ? mem[addr] : '0;

`ifdef MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_last;

  assign clr_last = (32'(clr_addr_q) == DEPTH - 1);
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = clr_addr_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      ST_RESET: begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // The clear counter is reset with the FSM so a reset mid-clear restarts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_addr_q <= '0;
    end else begin
      clr_addr_q <= clr_addr_d;
    end
  end
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end
`endif

  // Read pipeline: stage 0 captures the word at the accept edge. Data stages
  // only advance behind a valid entry, so rd_data holds between responses.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_err_d    = pipe_err_q;
    pipe_dat_d    = pipe_dat_q;
    pipe_vld_d[0] = rd_accept;
    pipe_err_d[0] = rd_accept && !in_range;
    if (rd_accept) begin
      pipe_dat_d[0] = rd_word;
    end
    for (int k = 1; k < int'(RD_LAT); k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_err_d[k] = pipe_err_q[k-1];
      if (pipe_vld_q[k-1]) begin
        pipe_dat_d[k] = pipe_dat_q[k-1];
      end
    end
    wr_err_d = wr_accept && !in_range;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RESET;
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      pipe_dat_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_err_q <= pipe_err_d;
      pipe_dat_q <= pipe_dat_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // The array has no reset; writes only happen in CLEAR or on an accepted
  // in-range write, and neither can occur while rst holds the FSM in RESET.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_accept && in_range) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (wr_be[b]) begin
          mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_valid = pipe_vld_q[RD_LAT-1];
  assign rd_err   = pipe_err_q[RD_LAT-1];
  assign rd_data  = pipe_dat_q[RD_LAT-1];
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_mem_pipe_param.sv
// ---------------------------------------------------------------------------
// tb_mem_pipe_param
// Drives two mem_pipe_param instances with the same request stream:
//   instance 0: DEPTH 256, RD_LAT 1
//   instance 1: DEPTH 200, RD_LAT 4
// A behavioural memory model predicts every output each cycle; directed
// literal expectations pin the model for the key scenarios. Honors
// MEM_CLEAR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mem_pipe_param;

`ifdef MEM_CLEAR_EN
  localparam bit          CLEAR_ON      = 1'b1;
  localparam int          READY_EDGES_A = 257;
  localparam int          READY_EDGES_B = 201;
  localparam logic [31:0] KEPT_10       = 32'h0000_0000;
`else
  localparam bit          CLEAR_ON      = 1'b0;
  localparam int          READY_EDGES_A = 1;
  localparam int          READY_EDGES_B = 1;
  localparam logic [31:0] KEPT_10       = 32'hDEAD_BEEF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        wr_rd;
  logic [7:0]  addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic        rdy  [2];
  logic        rv   [2];
  logic [31:0] rdat [2];
  logic        rerr [2];
  logic        werr [2];

  always #5 clk = ~clk;

  mem_pipe_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .wr_rd(wr_rd), .addr(addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rv[0]), .rd_data(rdat[0]), .rd_err(rerr[0]), .wr_err(werr[0])
  );

  mem_pipe_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .wr_rd(wr_rd), .addr(addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rv[1]), .rd_data(rdat[1]), .rd_err(rerr[1]), .wr_err(werr[1])
  );

  int checks = 0;
  int passes = 0;

  // Model state: word array, responses scheduled by due edge, ready countdown.
  logic [31:0] mm        [2][256];
  logic        ring_v    [2][8];
  logic [31:0] ring_d    [2][8];
  logic        ring_e    [2][8];
  int          ready_cnt [2];
  logic [31:0] last_data [2];
  logic        exp_werr  [2];
  int          edge_n = 0;

  // Observations of the DUTs, used by the literal expectations.
  int          obs_edge    [2];
  logic [31:0] obs_data    [2];
  logic        obs_err     [2];
  int          obs_rv_cnt  [2];
  int          obs_werr_cnt[2];
  int          cur_run     [2];
  int          max_run     [2];

  logic        s_rst, s_valid, s_wr, acc, in_rng, exp_v;
  logic [7:0]  s_addr;
  logic [31:0] s_data;
  logic [3:0]  s_be;
  int          slot, due;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? 256 : 200;
  endfunction

  function automatic int need_of(input int i);
    return 1 + (CLEAR_ON ? depth_of(i) : 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) mm[i][a] = 'x;
      for (int k = 0; k < 8; k++) ring_v[i][k] = 1'b0;
      ready_cnt[i] = 0;  last_data[i] = '0;  exp_werr[i] = 1'b0;
      obs_edge[i] = 0;   obs_data[i] = '0;   obs_err[i] = 1'b0;
      obs_rv_cnt[i] = 0; obs_werr_cnt[i] = 0; cur_run[i] = 0; max_run[i] = 0;
    end
  end

  // Model update at each rising edge, then compare 1 time unit later.
  always begin
    @(posedge clk);
    s_rst = rst; s_valid = req_valid; s_wr = wr_rd;
    s_addr = addr; s_data = wr_data; s_be = wr_be;
    edge_n++;
    slot = edge_n % 8;
    for (int i = 0; i < 2; i++) begin
      exp_werr[i] = 1'b0;
      if (!s_rst) begin
        ready_cnt[i] = 0;
        last_data[i] = '0;
        for (int k = 0; k < 8; k++) ring_v[i][k] = 1'b0;
      end else begin
        acc    = s_valid && (ready_cnt[i] >= need_of(i));
        in_rng = int'(s_addr) < depth_of(i);
        if (acc && s_wr) begin
          if (in_rng) begin
            for (int b = 0; b < 4; b++)
              if (s_be[b]) mm[i][s_addr][8*b +: 8] = s_data[8*b +: 8];
          end else begin
            exp_werr[i] = 1'b1;
          end
        end
        if (acc && !s_wr) begin
          due = (edge_n + lat_of(i) - 1) % 8;
          ring_v[i][due] = 1'b1;
          ring_d[i][due] = in_rng ? mm[i][s_addr] : 32'h0;
          ring_e[i][due] = !in_rng;
        end
        if (ready_cnt[i] < need_of(i)) begin
          ready_cnt[i]++;
          if (CLEAR_ON && ready_cnt[i] == need_of(i))
            for (int a = 0; a < 256; a++) mm[i][a] = '0;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("req_ready[%0d]", i), {31'b0, rdy[i]},
                  {31'b0, s_rst && (ready_cnt[i] >= need_of(i))});
      checkOutput($sformatf("wr_err[%0d]", i), {31'b0, werr[i]}, {31'b0, exp_werr[i]});
      exp_v = s_rst && ring_v[i][slot];
      checkOutput($sformatf("rd_valid[%0d]", i), {31'b0, rv[i]}, {31'b0, exp_v});
      if (exp_v) begin
        checkOutput($sformatf("rd_err[%0d]", i), {31'b0, rerr[i]}, {31'b0, ring_e[i][slot]});
        if (!$isunknown(ring_d[i][slot]))
          checkOutput($sformatf("rd_data[%0d]", i), rdat[i], ring_d[i][slot]);
        last_data[i]      = ring_d[i][slot];
        ring_v[i][slot]   = 1'b0;
      end else begin
        if (!$isunknown(last_data[i]))
          checkOutput($sformatf("rd_data_hold[%0d]", i), rdat[i], last_data[i]);
        if (!s_rst)
          checkOutput($sformatf("rd_err_rst[%0d]", i), {31'b0, rerr[i]}, 32'h0);
      end
      if (rv[i] === 1'b1) begin
        obs_edge[i] = edge_n; obs_data[i] = rdat[i]; obs_err[i] = rerr[i];
        obs_rv_cnt[i]++;
        cur_run[i]++;
        if (cur_run[i] > max_run[i]) max_run[i] = cur_run[i];
      end else begin
        cur_run[i] = 0;
      end
      if (werr[i] === 1'b1) obs_werr_cnt[i]++;
    end
  end

  task automatic applyStimulus(input logic v, input logic w, input logic [7:0] a,
                               input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    req_valid = v; wr_rd = w; addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  task automatic waitReady(input int idx, input int bound, output int n);
    n = 0;
    while (rdy[idx] !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (rdy[idx] !== 1'b1)
      checkOutput($sformatf("ready_timeout[%0d]", idx), {31'b0, rdy[idx]}, 32'h1);
  endtask

  // Called at a negedge with rst low; releases it and pins the ready delay.
  task automatic releaseReset();
    int nb, na;
    rst = 1'b1;
    waitReady(1, 400, nb);
    waitReady(0, 400, na);
    checkOutput("ready_edges_b", nb, READY_EDGES_B);
    checkOutput("ready_edges_a", nb + na, READY_EDGES_A);
  endtask

  task automatic assertReset(input int hold);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    for (int k = 0; k < hold; k++) @(negedge clk);
    checkOutput("rst_ready_a", {31'b0, rdy[0]}, 32'h0);
    checkOutput("rst_ready_b", {31'b0, rdy[1]}, 32'h0);
    checkOutput("rst_valid_b", {31'b0, rv[1]}, 32'h0);
    checkOutput("rst_data_b", rdat[1], 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_edge, rv_a0, rv_b0, we_a0, we_b0;
    rst = 1'b0; req_valid = 1'b0; wr_rd = 1'b0; addr = '0; wr_data = '0; wr_be = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready_a", {31'b0, rdy[0]}, 32'h0);
    checkOutput("reset_data_a", rdat[0], 32'h0);
    releaseReset();

    $display("[TB] full-word write then read of 0x10");
    applyStimulus(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    acc_edge = edge_n + 1;
    idleCycles(6);
    checkOutput("lat_a", obs_edge[0] - acc_edge + 1, 32'd1);
    checkOutput("lat_b", obs_edge[1] - acc_edge + 1, 32'd4);
    checkOutput("data_10_a", obs_data[0], 32'hDEAD_BEEF);
    checkOutput("data_10_b", obs_data[1], 32'hDEAD_BEEF);
    checkOutput("err_10_b", {31'b0, obs_err[1]}, 32'h0);

    $display("[TB] byte-enable merge at 0x20");
    applyStimulus(1'b1, 1'b1, 8'h20, 32'h1122_3344, 4'hF);
    applyStimulus(1'b1, 1'b1, 8'h20, 32'hAABB_CCDD, 4'b0101);
    applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    idleCycles(6);
    checkOutput("merge_a", obs_data[0], 32'h11BB_33DD);
    checkOutput("merge_b", obs_data[1], 32'h11BB_33DD);

    $display("[TB] write-then-read next cycle, then streaming reads");
    applyStimulus(1'b1, 1'b1, 8'h30, 32'h0000_0005, 4'hF);
    applyStimulus(1'b1, 1'b0, 8'h30, 32'h0, 4'h0);
    idleCycles(6);
    checkOutput("wfirst_a", obs_data[0], 32'h5);
    checkOutput("wfirst_b", obs_data[1], 32'h5);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b1, 8'(i), 32'hA0 + 32'(i), 4'hF);
    idleCycles(1);
    max_run[0] = 0; max_run[1] = 0;
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b0, 8'(i), 32'h0, 4'h0);
    idleCycles(6);
    checkOutput("run_a", max_run[0], 32'd8);
    checkOutput("run_b", max_run[1], 32'd8);
    checkOutput("last_a", obs_data[0], 32'hA7);
    checkOutput("last_b", obs_data[1], 32'hA7);

    $display("[TB] address 250: in range for a, out of range for b");
    we_a0 = obs_werr_cnt[0]; we_b0 = obs_werr_cnt[1];
    applyStimulus(1'b1, 1'b1, 8'd250, 32'h1234_5678, 4'hF);
    applyStimulus(1'b1, 1'b0, 8'd250, 32'h0, 4'h0);
    idleCycles(6);
    checkOutput("werr_cnt_a", obs_werr_cnt[0] - we_a0, 32'd0);
    checkOutput("werr_cnt_b", obs_werr_cnt[1] - we_b0, 32'd1);
    checkOutput("oor_data_a", obs_data[0], 32'h1234_5678);
    checkOutput("oor_err_a", {31'b0, obs_err[0]}, 32'h0);
    checkOutput("oor_data_b", obs_data[1], 32'h0);
    checkOutput("oor_err_b", {31'b0, obs_err[1]}, 32'h1);

    $display("[TB] reset with reads in flight");
    rv_a0 = obs_rv_cnt[0]; rv_b0 = obs_rv_cnt[1];
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 8'(i), 32'h0, 4'h0);
    assertReset(3);
    releaseReset();
    idleCycles(6);
    checkOutput("inflight_a", obs_rv_cnt[0] - rv_a0, 32'd3);
    checkOutput("inflight_b", obs_rv_cnt[1] - rv_b0, 32'd0);

    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    idleCycles(6);
    checkOutput("after_rst_a", obs_data[0], KEPT_10);
    checkOutput("after_rst_b", obs_data[1], KEPT_10);

`ifdef MEM_CLEAR_EN
    $display("[TB] reset in the middle of the clear");
    applyStimulus(1'b1, 1'b1, 8'h05, 32'h5555_5555, 4'hF);
    idleCycles(1);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (101) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    releaseReset();
    applyStimulus(1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
    idleCycles(6);
    checkOutput("cleared_a", obs_data[0], 32'h0);
    checkOutput("cleared_b", obs_data[1], 32'h0);
`endif

    idleCycles(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
